// File: rtl/multdiv_if.sv
// ============================================================================
// multdiv_if : request/result bundle between execute and the mult/div engine
// Rev 1.0
// ============================================================================
`default_nettype none

interface multdiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
// multdiv_unit : multi-cycle MULT/MULTU/DIV/DIVU engine producing {hi, lo}
// Rev 1.0
// ============================================================================
`default_nettype none

module multdiv_unit #(
    parameter int MUL_LAT = 3
) (
    input  wire logic  clk,
    input  wire logic  reset,
    multdiv_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    localparam logic [5:0] C_MUL_CNT = 6'(MUL_LAT - 1);
    localparam logic [5:0] C_DIV_CNT = 6'd32;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_signed;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_divisor;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Operand magnitudes for the divider, taken straight from the request.
    logic        w_in_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

    assign w_in_signed = ~bus.op[0];
    assign w_a_mag     = (w_in_signed & bus.a[31]) ? -bus.a : bus.a;
    assign w_b_mag     = (w_in_signed & bus.b[31]) ? -bus.b : bus.b;

    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_ge;

    assign w_shift = {r_rem, r_quo[31]};
    assign w_trial = w_shift - {1'b0, r_divisor};
    assign w_ge    = ~w_trial[32];

    logic [63:0] w_prod;
    assign w_prod = {{32{r_signed & r_a[31]}}, r_a} * {{32{r_signed & r_b[31]}}, r_b};

    // Sign fix-up: quotient truncates toward zero, remainder follows the dividend.
    logic        w_q_neg;
    logic        w_r_neg;
    logic        w_div0;
    logic [31:0] w_div_lo;
    logic [31:0] w_div_hi;

    assign w_q_neg  = r_signed & (r_a[31] ^ r_b[31]);
    assign w_r_neg  = r_signed & r_a[31];
    assign w_div0   = (r_b == 32'd0);
    assign w_div_lo = w_div0 ? 32'hFFFF_FFFF : (w_q_neg ? -r_quo : r_quo);
    assign w_div_hi = w_div0 ? r_a           : (w_r_neg ? -r_rem : r_rem);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_signed  <= 1'b0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_divisor <= 32'd0;
            r_done    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_signed  <= w_in_signed;
                            r_a       <= bus.a;
                            r_b       <= bus.b;
                            r_rem     <= 32'd0;
                            r_quo     <= w_a_mag;
                            r_divisor <= w_b_mag;
                            r_cnt     <= bus.op[1] ? C_DIV_CNT : C_MUL_CNT;
                            r_state   <= bus.op[1] ? S_DIV : S_MUL;
                        end
                    end
                    S_MUL: begin
                        if (r_cnt == 6'd0) begin
                            r_done  <= 1'b1;
                            r_hi    <= w_prod[63:32];
                            r_lo    <= w_prod[31:0];
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                    S_DIV: begin
                        if (r_cnt == 6'd0) begin
                            r_done  <= 1'b1;
                            r_hi    <= w_div_hi;
                            r_lo    <= w_div_lo;
                            r_state <= S_IDLE;
                        end else begin
                            // One restoring step; divide-by-zero garbage is overridden at the end.
                            r_cnt <= r_cnt - 6'd1;
                            r_rem <= w_ge ? w_trial[31:0] : w_shift[31:0];
                            r_quo <= {r_quo[30:0], w_ge};
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
// tb_multdiv_unit : directed literal cases plus random traffic against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_unit;

    localparam int MUL_LAT = 3;

    logic clk = 1'b0;
    logic reset;
    logic chk_en = 1'b0;

    multdiv_if bus ();

    multdiv_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        int     ia;
        int     ib;
        case (op)
            2'b00: begin
                sa = longint'(int'(a));
                sb = longint'(int'(b));
                return 64'(sa * sb);
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b11) return {a % b, a / b};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ia = int'(a);
                ib = int'(b);
                return {32'(ia % ib), 32'(ia / ib)};
            end
        endcase
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    int          m_remain = 0;
    logic [63:0] m_pend = 64'd0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else begin
            m_done = 1'b0;
            if (bus.flush) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_hi   = m_pend[63:32];
                    m_lo   = m_pend[31:0];
                end
            end else if (bus.start) begin
                m_busy   = 1'b1;
                m_remain = bus.op[1] ? 33 : MUL_LAT;
                m_pend   = ref_result(bus.op, bus.a, bus.b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, bus.busy}, {31'd0, m_busy});
            check("done", {31'd0, bus.done}, {31'd0, m_done});
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        wait_done(n);
        check({name, " latency"}, 32'(n), op[1] ? 32'd33 : 32'(MUL_LAT));
        check({name, " busy@done"}, {31'd0, bus.busy}, 32'd0);
        check({name, " hi"}, bus.hi, exp_hi);
        check({name, " lo"}, bus.lo, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom % 16);
            4:       return -32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.flush = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        tick();

        run_op("mult -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        tick();
        run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult b2b", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("div s0", 2'b10, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
        run_op("divu 0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);

        // Flush at cycle 10 of a divide, with a competing start in the same cycle.
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd555; bus.b = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'd9;
        tick();
        bus.flush = 1'b0; bus.start = 1'b0;
        check("flush busy", {31'd0, bus.busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.done) seen++;
        end
        check("flush no done", 32'(seen), 32'd0);
        check("flush hi kept", bus.hi, 32'h0000_1234);
        check("flush lo kept", bus.lo, 32'hFFFF_FFFF);

        // Start while busy must not disturb the in-flight divide.
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd6;
        tick();
        bus.start = 1'b0;
        wait_done(n);
        check("ignored start latency", 32'(n + 4), 32'd33);
        check("ignored start hi", bus.hi, 32'd2);
        check("ignored start lo", bus.lo, 32'd14);
        tick();

        // Reset in cycle 5 of a divide.
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'hFFFF_FF9C; bus.b = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset busy", {31'd0, bus.busy}, 32'd0);
        check("midreset hi", bus.hi, 32'd0);
        check("midreset lo", bus.lo, 32'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.done) seen++;
        end
        check("midreset no done", 32'(seen), 32'd0);

        // Random traffic; the per-cycle compare process checks against the model.
        repeat (4000) begin
            bus.start = (($urandom % 3) == 0);
            bus.op    = 2'($urandom_range(3, 0));
            bus.a     = pick();
            bus.b     = pick();
            bus.flush = (($urandom % 50) == 0);
            reset     = (($urandom % 500) == 0);
            tick();
        end
        bus.start = 1'b0;
        bus.flush = 1'b0;
        reset     = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
